// File: rtl/axi_lite_row_loader_if.sv
// AXI4-Lite write/read channel bundle between the row loader (master) and the
// pixel generator register file (slave).
interface axi_lite_row_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awvalid, output awready,
        input wdata, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi_lite_row_loader.sv
// AXI4-Lite initiator: writes one grid row as 32-bit words, then sets the row-ready flag.
// Define LOADER_READBACK_EN to verify every word by reading it back before the flag write.
module axi_lite_row_loader #(
    parameter int AXI_LITE_ADDR_WIDTH = 8,
    parameter int ROW_WIDTH           = 1280,
    parameter int BASE_ADDR           = 0,
    parameter int FLAG_INDEX          = 41
) (
    input  logic                 m_axi_lite_aclk,
    input  logic                 axi_resetn,
    input  logic [ROW_WIDTH-1:0] row_data,
    input  logic                 row_valid,
    output logic                 row_ready,
    output logic                 done,
    output logic                 err,
    axi_lite_row_loader_if.master m_axi_lite
);
    localparam int         WORDS     = ROW_WIDTH / 32;
    localparam int         IDX_W     = $clog2(WORDS + 1);
    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;

    state_t                   state_reg, state_next;
    logic [ROW_WIDTH-1:0]     row_reg;
    logic [IDX_W-1:0]         idx_reg;
    logic                     aw_done_reg, w_done_reg, err_reg;
    logic [31:0]              row_word [WORDS];
    logic                     aw_hs, w_hs, wr_req_done, is_flag, b_ok;
    logic [AXI_LITE_ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]              wr_word;

    function automatic logic [AXI_LITE_ADDR_WIDTH-1:0] reg_addr(input int index);
        return AXI_LITE_ADDR_WIDTH'(BASE_ADDR + 4 * index);
    endfunction

    // Word 0 is the leftmost 32 bits of the row.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            assign row_word[gi] = row_reg[ROW_WIDTH-1-32*gi -: 32];
        end
    endgenerate

    assign is_flag     = (idx_reg == IDX_W'(WORDS));
    assign b_ok        = (m_axi_lite.bresp == RESP_OKAY);
    assign aw_hs       = (state_reg == WR_REQ) && !aw_done_reg && m_axi_lite.awready;
    assign w_hs        = (state_reg == WR_REQ) && !w_done_reg && m_axi_lite.wready;
    assign wr_req_done = (aw_done_reg || aw_hs) && (w_done_reg || w_hs);
    assign wr_addr     = is_flag ? reg_addr(FLAG_INDEX) : reg_addr(int'(idx_reg));
    assign wr_word     = is_flag ? 32'h1 : row_word[idx_reg];

`ifdef LOADER_READBACK_EN
    logic [IDX_W-1:0] rd_idx_reg;
    logic             rd_bad, rd_last, wr_last;

    assign wr_last = (idx_reg == IDX_W'(WORDS - 1));
    assign rd_last = (rd_idx_reg == IDX_W'(WORDS - 1));
    assign rd_bad  = (m_axi_lite.rresp != RESP_OKAY) || (m_axi_lite.rdata != row_word[rd_idx_reg]);

    always_ff @(posedge m_axi_lite_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            rd_idx_reg <= '0;
        end else if (state_reg == IDLE && row_valid) begin
            rd_idx_reg <= '0;
        end else if (state_reg == RD_RESP && m_axi_lite.rvalid && !rd_bad) begin
            rd_idx_reg <= rd_idx_reg + 1'b1;
        end
    end
`else
    logic unused_rd;
    assign unused_rd = ^{m_axi_lite.arready, m_axi_lite.rdata, m_axi_lite.rresp, m_axi_lite.rvalid};
`endif

    always_ff @(posedge m_axi_lite_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (row_valid) state_next = WR_REQ;
            WR_REQ:  if (wr_req_done) state_next = WR_RESP;
            WR_RESP: begin
                if (m_axi_lite.bvalid) begin
                    if (!b_ok || is_flag) state_next = DONE;
`ifdef LOADER_READBACK_EN
                    else if (wr_last) state_next = RD_REQ;
`endif
                    else state_next = WR_REQ;
                end
            end
`ifdef LOADER_READBACK_EN
            RD_REQ:  if (m_axi_lite.arready) state_next = RD_RESP;
            RD_RESP: begin
                if (m_axi_lite.rvalid) begin
                    if (rd_bad) state_next = DONE;
                    else if (rd_last) state_next = WR_REQ;
                    else state_next = RD_REQ;
                end
            end
`endif
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Per-channel completion flags let AW and W be accepted in either order.
    always_ff @(posedge m_axi_lite_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            row_reg     <= '0;
            idx_reg     <= '0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            if (state_reg != WR_REQ) begin
                aw_done_reg <= 1'b0;
                w_done_reg  <= 1'b0;
            end else begin
                if (aw_hs) aw_done_reg <= 1'b1;
                if (w_hs)  w_done_reg  <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (row_valid) begin
                        row_reg <= row_data;
                        idx_reg <= '0;
                        err_reg <= 1'b0;
                    end
                end
                WR_RESP: begin
                    if (m_axi_lite.bvalid) begin
                        if (!b_ok) err_reg <= 1'b1;
                        else       idx_reg <= idx_reg + 1'b1;
                    end
                end
`ifdef LOADER_READBACK_EN
                RD_RESP: if (m_axi_lite.rvalid && rd_bad) err_reg <= 1'b1;
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        row_ready          = (state_reg == IDLE);
        done               = (state_reg == DONE);
        err                = err_reg;
        m_axi_lite.awvalid = (state_reg == WR_REQ) && !aw_done_reg;
        m_axi_lite.wvalid  = (state_reg == WR_REQ) && !w_done_reg;
        m_axi_lite.awaddr  = (state_reg == WR_REQ) ? wr_addr : '0;
        m_axi_lite.wdata   = (state_reg == WR_REQ) ? wr_word : 32'h0;
        m_axi_lite.bready  = (state_reg == WR_RESP);
`ifdef LOADER_READBACK_EN
        m_axi_lite.arvalid = (state_reg == RD_REQ);
        m_axi_lite.araddr  = (state_reg == RD_REQ) ? reg_addr(int'(rd_idx_reg)) : '0;
        m_axi_lite.rready  = (state_reg == RD_RESP);
`else
        m_axi_lite.arvalid = 1'b0;
        m_axi_lite.araddr  = '0;
        m_axi_lite.rready  = 1'b0;
`endif
    end
endmodule

// File: tb/tb_axi_lite_row_loader.sv
// Directed bench for axi_lite_row_loader with a behavioural AXI4-Lite register-file responder.
// Readback scenarios compile in when LOADER_READBACK_EN is defined.
module tb_axi_lite_row_loader;
    localparam int AW    = 8;
    localparam int RW    = 1280;
    localparam int WORDS = RW / 32;

    logic          clk = 1'b0;
    logic          axi_resetn = 1'b0;
    logic [RW-1:0] row_data;
    logic          row_valid, row_ready, done, err;

    always #5 clk = ~clk;

    axi_lite_row_loader_if #(.ADDR_WIDTH(AW)) bus ();

    axi_lite_row_loader #(
        .AXI_LITE_ADDR_WIDTH(AW), .ROW_WIDTH(RW), .BASE_ADDR(0), .FLAG_INDEX(41)
    ) dut (
        .m_axi_lite_aclk(clk), .axi_resetn(axi_resetn),
        .row_data(row_data), .row_valid(row_valid), .row_ready(row_ready),
        .done(done), .err(err), .m_axi_lite(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // responder configuration and observation logs
    int          aw_delay  = 0;
    int          err_word  = -1;
    bit          corrupt7  = 1'b0;
    logic [31:0] mem [64];
    logic [7:0]  wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic [7:0]  rd_addr_q [$];
    int          aw_hi_q [$];
    int          done_cnt, b_cnt, stab_err, extra_valid, ar_seen;
    bit          aw_got, w_got, ar_got, pend_aw, pend_w;
    logic [7:0]  aw_lat, ar_lat, prev_awaddr;
    logic [31:0] w_lat, prev_wdata;
    int          aw_wait, aw_hi;

    // Drives ready/response signals on the falling edge and samples handshakes 1 ns before the rising edge.
    initial begin
        {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid} = '0;
        bus.bresp = 2'b00; bus.rresp = 2'b00; bus.rdata = 32'h0;
        {aw_got, w_got, ar_got, pend_aw, pend_w} = '0;
        aw_wait = 0; aw_hi = 0;
        forever begin
            @(negedge clk);
            if (!axi_resetn) begin
                {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid} = '0;
            end else begin
                bus.awready = bus.awvalid && !aw_got && (aw_wait >= aw_delay);
                bus.wready  = bus.wvalid && !w_got;
                bus.bvalid  = aw_got && w_got;
                bus.bresp   = (wr_addr_q.size() == err_word) ? 2'b10 : 2'b00;
                bus.arready = bus.arvalid && !ar_got;
                bus.rvalid  = ar_got;
                bus.rresp   = 2'b00;
                if (ar_got) bus.rdata = mem[ar_lat[7:2]] ^ ((corrupt7 && ar_lat == 8'h1C) ? 32'h1 : 32'h0);
            end
            #4;
            if (done) done_cnt++;
            if (!axi_resetn) begin
                {aw_got, w_got, ar_got, pend_aw, pend_w} = '0;
                aw_wait = 0; aw_hi = 0;
            end else begin
                if (pend_aw && (!bus.awvalid || bus.awaddr !== prev_awaddr)) stab_err++;
                if (pend_w && (!bus.wvalid || bus.wdata !== prev_wdata)) stab_err++;
                pend_aw = bus.awvalid && !bus.awready; prev_awaddr = bus.awaddr;
                pend_w  = bus.wvalid && !bus.wready;   prev_wdata  = bus.wdata;
                if ((bus.awvalid && aw_got) || (bus.wvalid && w_got)) extra_valid++;
                if (bus.arvalid) ar_seen++;
                if (bus.awvalid) aw_hi++;
                if (bus.awvalid && !bus.awready) aw_wait++;
                if (bus.awvalid && bus.awready) begin
                    aw_got = 1'b1; aw_lat = bus.awaddr;
                    aw_hi_q.push_back(aw_hi); aw_hi = 0; aw_wait = 0;
                end
                if (bus.wvalid && bus.wready) begin w_got = 1'b1; w_lat = bus.wdata; end
                if (bus.bvalid && bus.bready) begin
                    b_cnt++;
                    mem[aw_lat[7:2]] = w_lat;
                    wr_addr_q.push_back(aw_lat); wr_data_q.push_back(w_lat);
                    aw_got = 1'b0; w_got = 1'b0;
                end
                if (bus.arvalid && bus.arready) begin
                    ar_got = 1'b1; ar_lat = bus.araddr; rd_addr_q.push_back(bus.araddr);
                end
                if (bus.rvalid && bus.rready) ar_got = 1'b0;
            end
        end
    end

    function automatic logic [31:0] pat(input int kind, input int i);
        case (kind)
            0:       return 32'hA500_0000 + 32'(i);
            1:       return 32'hDEAD_BEEF ^ (32'(i) * 32'h0101_0101);
            2:       return {16'hC0DE, 16'(i)};
            default: return ~(32'hA500_0000 + 32'(i));
        endcase
    endfunction

    function automatic logic [RW-1:0] make_row(input int kind);
        logic [RW-1:0] r;
        r = '0;
        for (int i = 0; i < WORDS; i++) r[RW-1-32*i -: 32] = pat(kind, i);
        return r;
    endfunction

    // Number of logged writes among the first n that differ from the expected address/data sequence.
    function automatic int write_mismatches(input int kind, input int n);
        int          bad;
        logic [7:0]  ea;
        logic [31:0] ed;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (i < WORDS) begin ea = 8'(4 * i); ed = pat(kind, i); end
            else begin ea = 8'hA4; ed = 32'h1; end
            if (i >= wr_addr_q.size()) bad++;
            else if (wr_addr_q[i] !== ea || wr_data_q[i] !== ed) bad++;
        end
        return bad;
    endfunction

    function automatic int flag_writes();
        int n;
        n = 0;
        foreach (wr_addr_q[i]) if (wr_addr_q[i] == 8'hA4) n++;
        return n;
    endfunction

    task automatic clear_logs();
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete(); aw_hi_q.delete();
        done_cnt = 0; b_cnt = 0; stab_err = 0; extra_valid = 0; ar_seen = 0;
    endtask

    // Offers a row; returns on the falling edge after the accepting rising edge.
    task automatic send_row(input logic [RW-1:0] row, input bit hold, output bit ok);
        @(negedge clk);
        row_data = row; row_valid = 1'b1; ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (row_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        if (!hold) row_valid = 1'b0;
    endtask

    // lat counts falling edges from the one after acceptance (1) up to the one where done is seen.
    task automatic wait_done(input int bound, output int lat, output int rr_hi, output bit ok);
        lat = 1; rr_hi = 0; ok = 1'b0;
        while (lat < bound) begin
            if (done) begin ok = 1'b1; break; end
            if (row_ready) rr_hi++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        row_valid = 1'b0; row_data = '0; axi_resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({row_ready, done, err, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} !== 8'b1000_0000) begin
            n_fail++; $display("FAIL reset_flags: got %b, want 10000000",
                {row_ready, done, err, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready});
        end
        n_checks++;
        if (bus.awaddr !== 8'h00 || bus.araddr !== 8'h00) begin
            n_fail++; $display("FAIL reset_addr: awaddr %h araddr %h, want 00 00", bus.awaddr, bus.araddr);
        end
        n_checks++;
        if (bus.wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h, want 0", bus.wdata); end
        axi_resetn = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({row_ready, bus.awvalid, done} !== 3'b100) begin
            n_fail++; $display("FAIL post_reset_idle: got %b, want 100", {row_ready, bus.awvalid, done});
        end
        $display("reset: row_ready=%0b err=%0b", row_ready, err);
    endtask

    task automatic test_basic();
        bit ok; int lat, rr_hi, exp_total;
        clear_logs();
        send_row(make_row(0), 1'b0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_accept: row not accepted, want accepted"); end
        wait_done(1000, lat, rr_hi, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_done: no done within %0d cycles, want done", lat); end
        repeat (2) @(negedge clk);
`ifdef LOADER_READBACK_EN
        exp_total = 84 + 40 * 2;
`else
        exp_total = 84;
`endif
        // total cycles = accepting cycle + cycles up to and including the done cycle
        n_checks++; if (lat + 1 !== exp_total) begin n_fail++; $display("FAIL basic_cycles: got %0d, want %0d", lat + 1, exp_total); end
        n_checks++; if (wr_addr_q.size() !== 41) begin n_fail++; $display("FAIL basic_write_count: got %0d, want 41", wr_addr_q.size()); end
        n_checks++; if (write_mismatches(0, 41) !== 0) begin n_fail++; $display("FAIL basic_write_seq: %0d bad entries, want 0", write_mismatches(0, 41)); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d, want 1", done_cnt); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b, want 0", err); end
        n_checks++; if (rr_hi !== 0) begin n_fail++; $display("FAIL basic_row_ready_busy: high %0d cycles, want 0", rr_hi); end
        n_checks++; if (stab_err !== 0) begin n_fail++; $display("FAIL basic_stability: got %0d, want 0", stab_err); end
`ifdef LOADER_READBACK_EN
        n_checks++; if (rd_addr_q.size() !== 40) begin n_fail++; $display("FAIL basic_read_count: got %0d, want 40", rd_addr_q.size()); end
`else
        n_checks++; if (ar_seen !== 0) begin n_fail++; $display("FAIL basic_no_reads: arvalid %0d cycles, want 0", ar_seen); end
`endif
        $display("row basic: writes=%0d reads=%0d err=%0b cycles=%0d", wr_addr_q.size(), rd_addr_q.size(), err, lat + 1);
    endtask

    task automatic test_aw_delay();
        bit ok; int lat, rr_hi;
        clear_logs();
        aw_delay = 3;
        send_row(make_row(1), 1'b0, ok);
        wait_done(2000, lat, rr_hi, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL awdly_done: no done within %0d cycles, want done", lat); end
        repeat (2) @(negedge clk);
        aw_delay = 0;
        // awready withheld for 3 sampled cycles, so awvalid is seen high 4 cycles including the accepting one
        n_checks++;
        if (aw_hi_q.size() == 0) begin n_fail++; $display("FAIL awdly_hold: no AW handshake, want 4 cycles"); end
        else if (aw_hi_q[0] !== 4) begin n_fail++; $display("FAIL awdly_hold: got %0d cycles, want 4", aw_hi_q[0]); end
        n_checks++; if (extra_valid !== 0) begin n_fail++; $display("FAIL awdly_valid_after_hs: got %0d, want 0", extra_valid); end
        n_checks++; if (b_cnt !== 41) begin n_fail++; $display("FAIL awdly_b_count: got %0d, want 41", b_cnt); end
        n_checks++; if (stab_err !== 0) begin n_fail++; $display("FAIL awdly_stability: got %0d, want 0", stab_err); end
        n_checks++; if (write_mismatches(1, 41) !== 0 || wr_addr_q.size() !== 41) begin
            n_fail++; $display("FAIL awdly_write_seq: %0d bad of %0d, want 0 of 41", write_mismatches(1, 41), wr_addr_q.size());
        end
        $display("row aw_delay: writes=%0d bresp_hs=%0d err=%0b cycles=%0d", wr_addr_q.size(), b_cnt, err, lat + 1);
    endtask

    task automatic test_bresp_error();
        bit ok; int lat, rr_hi;
        clear_logs();
        err_word = 5;
        send_row(make_row(2), 1'b0, ok);
        wait_done(1000, lat, rr_hi, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL berr_done: no done within %0d cycles, want done", lat); end
        repeat (2) @(negedge clk);
        err_word = -1;
        n_checks++; if (wr_addr_q.size() !== 6) begin n_fail++; $display("FAIL berr_write_count: got %0d, want 6", wr_addr_q.size()); end
        n_checks++; if (write_mismatches(2, 6) !== 0) begin n_fail++; $display("FAIL berr_write_seq: %0d bad, want 0", write_mismatches(2, 6)); end
        n_checks++; if (flag_writes() !== 0) begin n_fail++; $display("FAIL berr_flag: got %0d flag writes, want 0", flag_writes()); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL berr_err: got %b, want 1", err); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL berr_done_pulses: got %0d, want 1", done_cnt); end
        $display("row bresp_err: writes=%0d err=%0b", wr_addr_q.size(), err);
        clear_logs();
        send_row(make_row(0), 1'b0, ok);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL berr_clear_on_accept: got %b, want 0", err); end
        wait_done(1000, lat, rr_hi, ok);
        repeat (2) @(negedge clk);
        n_checks++; if (!ok || err !== 1'b0 || wr_addr_q.size() !== 41) begin
            n_fail++; $display("FAIL berr_recover: done %b err %b writes %0d, want 1 0 41", ok, err, wr_addr_q.size());
        end
        $display("row after_err: writes=%0d err=%0b", wr_addr_q.size(), err);
    endtask

    task automatic test_reset_mid();
        bit ok; int av;
        clear_logs();
        send_row(make_row(3), 1'b0, ok);
        ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (wr_addr_q.size() == 20 && bus.awvalid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_reach_word20: writes %0d, want 20 with awvalid", wr_addr_q.size()); end
        #2 axi_resetn = 1'b0;
        #1;
        n_checks++;
        if ({bus.awvalid, bus.wvalid, bus.bready, done, row_ready} !== 5'b00001) begin
            n_fail++; $display("FAIL rstmid_async: got %b, want 00001", {bus.awvalid, bus.wvalid, bus.bready, done, row_ready});
        end
        repeat (2) @(negedge clk);
        axi_resetn = 1'b1;
        av = 0;
        repeat (30) begin @(negedge clk); if (bus.awvalid) av++; end
        n_checks++; if (row_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_row_ready: got %b, want 1", row_ready); end
        n_checks++; if (av !== 0 || flag_writes() !== 0 || wr_addr_q.size() !== 20) begin
            n_fail++; $display("FAIL rstmid_quiet: awvalid %0d flag %0d writes %0d, want 0 0 20", av, flag_writes(), wr_addr_q.size());
        end
        $display("row reset_mid: writes=%0d flag_writes=%0d", wr_addr_q.size(), flag_writes());
    endtask

    task automatic test_back_to_back();
        bit ok; int lat, rr_hi, rr_total;
        clear_logs();
        rr_total = 0;
        send_row(make_row(0), 1'b1, ok);
        wait_done(1000, lat, rr_hi, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_first_done: no done within %0d cycles, want done", lat); end
        rr_total += rr_hi;
        row_data = make_row(1);
        n_checks++; if (write_mismatches(0, 41) !== 0 || wr_addr_q.size() !== 41) begin
            n_fail++; $display("FAIL b2b_first_writes: %0d bad of %0d, want 0 of 41", write_mismatches(0, 41), wr_addr_q.size());
        end
        wr_addr_q.delete(); wr_data_q.delete();
        @(negedge clk);
        n_checks++; if (row_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_done: got %b, want 1", row_ready); end
        @(negedge clk);
        n_checks++; if ({row_ready, bus.awvalid} !== 2'b01) begin
            n_fail++; $display("FAIL b2b_second_accept: row_ready,awvalid %b, want 01", {row_ready, bus.awvalid});
        end
        row_valid = 1'b0;
        wait_done(1000, lat, rr_hi, ok);
        rr_total += rr_hi;
        repeat (2) @(negedge clk);
        n_checks++; if (rr_total !== 0) begin n_fail++; $display("FAIL b2b_row_ready_busy: high %0d cycles, want 0", rr_total); end
        n_checks++; if (done_cnt !== 2) begin n_fail++; $display("FAIL b2b_done_pulses: got %0d, want 2", done_cnt); end
        n_checks++; if (write_mismatches(1, 41) !== 0 || wr_addr_q.size() !== 41) begin
            n_fail++; $display("FAIL b2b_second_writes: %0d bad of %0d, want 0 of 41", write_mismatches(1, 41), wr_addr_q.size());
        end
        $display("row back_to_back: second writes=%0d done_pulses=%0d", wr_addr_q.size(), done_cnt);
    endtask

    task automatic test_readback();
`ifdef LOADER_READBACK_EN
        bit ok; int lat, rr_hi;
        clear_logs();
        corrupt7 = 1'b1;
        send_row(make_row(0), 1'b0, ok);
        wait_done(1000, lat, rr_hi, ok);
        repeat (2) @(negedge clk);
        corrupt7 = 1'b0;
        n_checks++; if (!ok || err !== 1'b1) begin n_fail++; $display("FAIL rb_err: done %b err %b, want 1 1", ok, err); end
        n_checks++; if (wr_addr_q.size() !== 40 || write_mismatches(0, 40) !== 0) begin
            n_fail++; $display("FAIL rb_writes: %0d writes %0d bad, want 40 0", wr_addr_q.size(), write_mismatches(0, 40));
        end
        n_checks++;
        if (rd_addr_q.size() !== 8) begin n_fail++; $display("FAIL rb_read_count: got %0d, want 8", rd_addr_q.size()); end
        else if (rd_addr_q[7] !== 8'h1C) begin n_fail++; $display("FAIL rb_last_read: got %h, want 1c", rd_addr_q[7]); end
        n_checks++; if (flag_writes() !== 0) begin n_fail++; $display("FAIL rb_flag: got %0d, want 0", flag_writes()); end
        $display("row readback_corrupt: writes=%0d reads=%0d err=%0b", wr_addr_q.size(), rd_addr_q.size(), err);
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_aw_delay();
        test_bresp_error();
        test_reset_mid();
        test_back_to_back();
        test_readback();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end
endmodule
